button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Parametrised successor to the button parser feeding the CPU reset and user inputs from the top level. It conditions WIDTH asynchronous button/switch inputs:
- multi-stage synchronisation;
- one shared sample prescaler;
- symmetric integrating debounce, so both press and release are filtered;
- one-cycle press and release pulses;
- long-press detection;
- optional per-channel auto-repeat.

It sits between the board pins and the cpu_clk consumers: reset logic, MMIO button registers and switch reads.

Parameters:
- WIDTH, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flop depth; must be >= 2.
- SAMPLE_CNT_MAX, 40000, clk cycles per sample tick (500 us at 80 MHz); must be >= 1.
- PULSE_CNT_MAX, 200, consecutive differing samples needed to flip the debounced level; must be >= 1.
- LONG_CNT_MAX, 2000, sample ticks of held level before long_press fires; must be > PULSE_CNT_MAX.
- REPEAT_CNT_MAX, 400, sample ticks between auto-repeat pulses after long_press; must be >= 1.

Ports:
- clk  input  1  CPU clock; every register is in this domain.
- rst  input  1  asynchronous active-high reset.
- in  input  WIDTH  raw asynchronous inputs, active-high.
- repeat_en  input  WIDTH  per-channel auto-repeat enable; synchronous to clk.
- level  output  WIDTH  debounced level.
- press  output  WIDTH  one-cycle pulse on a debounced rising edge.
- release  output  WIDTH  one-cycle pulse on a debounced falling edge.
- long_press  output  WIDTH  one-cycle pulse, at most once per press.
- rpt  output  WIDTH  one-cycle auto-repeat pulse.

Behaviour:
- Reset (async assert, release synchronous to clk): all synchroniser flops, prescaler, per-channel counters and every output go to 0. Reset mid-press discards all state. If an input is still high after reset, press fires once the normal debounce completes.
- Synchroniser: SYNC_STAGES flops per bit; sync[i] is the last stage.
- Prescaler: counter 0..SAMPLE_CNT_MAX-1, wraps to 0. tick is high for exactly one cycle, combinationally, when count == SAMPLE_CNT_MAX-1. SAMPLE_CNT_MAX=1 gives tick every cycle. Counter width $clog2(SAMPLE_CNT_MAX+1).
- Debounce, per channel, evaluated only on tick:
  - if sync == level, diff_cnt <= 0;
  - else if diff_cnt == PULSE_CNT_MAX-1, level toggles and diff_cnt <= 0;
  - else diff_cnt increments.
  - A glitch shorter than PULSE_CNT_MAX consecutive samples never changes level. A single agreeing sample restarts the count.
- Edge pulses: press and release are registered. They are high in the first cycle in which the new level value is visible, for exactly one cycle.
- Hold counter, per channel:
  - cleared while level == 0;
  - on tick while level == 1, increments and saturates at LONG_CNT_MAX + REPEAT_CNT_MAX;
  - when it steps to LONG_CNT_MAX, long_press pulses for one cycle.
- Auto-repeat:
  - after long_press, if repeat_en[i] is high, rpt pulses every REPEAT_CNT_MAX ticks;
  - a separate repeat counter wraps, so the hold counter saturates without stopping repeats;
  - repeat_en is sampled at each tick; deasserting it suppresses further rpt but does not re-arm long_press;
  - release before LONG_CNT_MAX ticks gives no long_press and no rpt.
- Simultaneous events:
  - channels are fully independent, so several channels may pulse in the same cycle;
  - on one channel, long_press and rpt never coincide (the first rpt comes REPEAT_CNT_MAX ticks after long_press);
  - press and release never coincide.
- Latency:
  - rising in to press: SYNC_STAGES + up to PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 cycles;
  - with a tick-aligned stable input: exactly SYNC_STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX (±SAMPLE_CNT_MAX phase) + 1.

Decomposition:
- Shared package: counter-width helper constants (DIFF_W, HOLD_W, RPT_W, PRE_W derived via $clog2) and parameter legality checks (elaboration-time assertions on the minimum values above).
- One sub-module, button_channel: synchroniser, debounce, edge, hold and repeat logic for a single bit, instantiated WIDTH times with generate.
- The prescaler stays in the top of the block and fans tick out to all channels.

Test Plan:
Bench parameters: SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=10, REPEAT_CNT_MAX=5, WIDTH=4.
1. Clean press: in[0] held high from cycle 0 -> exactly one press[0] pulse, level[0]=1 within 2+12+4+1 cycles, no other channel toggles. Then in[0] low -> one release[0] pulse after the same bound.
2. Glitch rejection: in[1] high for 2 samples (8 cycles), then low -> level[1] stays 0, no press/release. Bounce pattern 1,1,0,1,1,1 (per sample) -> level rises only after the final three consecutive 1s.
3. Long press with repeat: repeat_en[2]=1, in[2] held 40 ticks -> press, long_press at hold tick 10, rpt at ticks 15, 20, 25, 30, 35, 40. With repeat_en[2]=0 -> long_press only, zero rpt.
4. Short press: in[3] held 6 ticks then released -> press and release only, no long_press/rpt.
5. Concurrency and reset: all four inputs rise in the same cycle -> press=4'hF in one cycle. rst asserted mid-hold (tick 7) with in still high -> all outputs 0 asynchronously; after rst deasserts, press re-fires after full debounce; long_press only 10 ticks after the new press.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants and elaboration helpers for the button conditioner block.
// Counter widths are derived from the channel timing parameters.
package button_conditioner_pkg;

    localparam int DEF_WIDTH          = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SAMPLE_CNT_MAX = 40000;
    localparam int DEF_PULSE_CNT_MAX  = 200;
    localparam int DEF_LONG_CNT_MAX   = 2000;
    localparam int DEF_REPEAT_CNT_MAX = 400;

    // Width of a counter that must hold values 0..max_val (never below 1 bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int pre_w(input int sample_cnt_max);
        return cnt_w(sample_cnt_max);
    endfunction

    function automatic int diff_w(input int pulse_cnt_max);
        return cnt_w(pulse_cnt_max);
    endfunction

    function automatic int hold_w(input int long_cnt_max, input int repeat_cnt_max);
        return cnt_w(long_cnt_max + repeat_cnt_max);
    endfunction

    function automatic int rpt_w(input int repeat_cnt_max);
        return cnt_w(repeat_cnt_max);
    endfunction

    localparam int PRE_W  = pre_w(DEF_SAMPLE_CNT_MAX);
    localparam int DIFF_W = diff_w(DEF_PULSE_CNT_MAX);
    localparam int HOLD_W = hold_w(DEF_LONG_CNT_MAX, DEF_REPEAT_CNT_MAX);
    localparam int RPT_W  = rpt_w(DEF_REPEAT_CNT_MAX);

    function automatic bit params_legal(
        input int width,
        input int sync_stages,
        input int sample_cnt_max,
        input int pulse_cnt_max,
        input int long_cnt_max,
        input int repeat_cnt_max
    );
        return (width >= 1) && (sync_stages >= 2) && (sample_cnt_max >= 1) &&
               (pulse_cnt_max >= 1) && (long_cnt_max > pulse_cnt_max) &&
               (repeat_cnt_max >= 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One conditioned input: synchroniser, integrating debounce, edge pulses,
// long-press detection and auto-repeat, all advanced by the shared sample tick.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int LONG_CNT_MAX   = DEF_LONG_CNT_MAX,
    parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic in_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic rpt_o
);

    localparam int DIFF_BITS = diff_w(PULSE_CNT_MAX);
    localparam int HOLD_BITS = hold_w(LONG_CNT_MAX, REPEAT_CNT_MAX);
    localparam int RPT_BITS  = rpt_w(REPEAT_CNT_MAX);

    localparam logic [DIFF_BITS-1:0] DIFF_LAST = DIFF_BITS'(PULSE_CNT_MAX - 1);
    localparam logic [HOLD_BITS-1:0] HOLD_PRE  = HOLD_BITS'(LONG_CNT_MAX - 1);
    localparam logic [HOLD_BITS-1:0] HOLD_LONG = HOLD_BITS'(LONG_CNT_MAX);
    localparam logic [HOLD_BITS-1:0] HOLD_SAT  = HOLD_BITS'(LONG_CNT_MAX + REPEAT_CNT_MAX);
    localparam logic [RPT_BITS-1:0]  RPT_LAST  = RPT_BITS'(REPEAT_CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DIFF_BITS-1:0]   diff_q, diff_d;
    logic [HOLD_BITS-1:0]   hold_q, hold_d;
    logic [RPT_BITS-1:0]    rcnt_q, rcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   rpt_q, rpt_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        diff_d    = diff_q;
        level_d   = level_q;
        hold_d    = hold_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;

        if (tick_i) begin
            if (sync == level_q) begin
                diff_d = '0;
            end else if (diff_q == DIFF_LAST) begin
                level_d   = ~level_q;
                diff_d    = '0;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                diff_d = diff_q + DIFF_BITS'(1);
            end

            if (level_q) begin
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_BITS'(1);
                end
                long_d = (hold_q == HOLD_PRE);
                // Repeat phase runs on its own wrapping counter once long_press has fired.
                if (hold_q >= HOLD_LONG) begin
                    if (rcnt_q == RPT_LAST) begin
                        rcnt_d = '0;
                        rpt_d  = repeat_en_i;
                    end else begin
                        rcnt_d = rcnt_q + RPT_BITS'(1);
                    end
                end
            end
        end

        if (!level_q) begin
            hold_d = '0;
            rcnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, as the synchroniser shift relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            diff_q    <= '0;
            hold_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], in_i};
            diff_q    <= diff_d;
            hold_q    <= hold_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign rpt_o        = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions WIDTH asynchronous button/switch inputs into clean clk-domain levels
// and event pulses; one shared prescaler paces every channel's sampling.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int LONG_CNT_MAX   = DEF_LONG_CNT_MAX,
    parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] repeat_en_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] long_press_o,
    output logic [WIDTH-1:0] rpt_o
);

    localparam int PRE_BITS = pre_w(SAMPLE_CNT_MAX);
    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(SAMPLE_CNT_MAX - 1);

    if (!params_legal(WIDTH, SYNC_STAGES, SAMPLE_CNT_MAX, PULSE_CNT_MAX,
                      LONG_CNT_MAX, REPEAT_CNT_MAX)) begin : g_param_check
        $error("button_conditioner: illegal parameter combination");
    end

    logic [PRE_BITS-1:0] pre_q, pre_d;
    logic                tick;

    // tick is combinational so channels act in the same cycle the count wraps.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .LONG_CNT_MAX  (LONG_CNT_MAX),
            .REPEAT_CNT_MAX(REPEAT_CNT_MAX)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick),
            .in_i        (in_i[i]),
            .repeat_en_i (repeat_en_i[i]),
            .level_o     (level_o[i]),
            .press_o     (press_o[i]),
            .release_o   (release_o[i]),
            .long_press_o(long_press_o[i]),
            .rpt_o       (rpt_o[i])
        );
    end

endmodule
